// File: rtl/inst_axi_rd_bridge.sv
// Bridges the fetch stage's SRAM-like req/addr_ok/data_ok port onto an AXI4 read
// channel pair, keeping up to MAX_OUTSTANDING single-beat reads in flight in order.
module inst_axi_rd_bridge #(
  parameter int        MAX_OUTSTANDING = 2,
  parameter logic [3:0] INST_ARID      = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,

  // fetch-side SRAM-like port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  axi_arid,

  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  ar_state_t   ar_state;
  logic [1:0]  cnt;
  logic        accept;
  logic        r_hs;

  // Writes, strobes, response codes and IDs carry no information for an
  // in-order, read-only, single-beat fetch path.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  // Acceptance looks only at registered state so fetch never sees a
  // combinational path from the AXI interconnect.
  assign accept            = resetn & inst_sram_req & ~inst_sram_wr & ~arvalid & (cnt < MAX_CNT);
  assign inst_sram_addr_ok = accept;

  assign rready   = (cnt != 2'd0);
  assign r_hs     = rvalid & rready;
  assign axi_arid = {3'b000, arvalid | (cnt != 2'd0)};

  assign arid    = INST_ARID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      araddr   <= 32'd0;
      arsize   <= 3'd0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (accept) begin
            ar_state <= AR_SEND;
            arvalid  <= 1'b1;
            araddr   <= inst_sram_addr;
            arsize   <= {1'b0, inst_sram_size};
          end
        end
        AR_SEND: begin
          if (arready) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
          end
        end
        default: begin
          ar_state <= AR_IDLE;
          arvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Accept is blocked at MAX_CNT and r_hs needs cnt != 0, so neither
  // direction can wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 2'd0;
    end else begin
      case ({accept, r_hs})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the returned word is a plain data register, so it is reset along with
  // the control flops to give fetch a defined value straight out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= 32'd0;
    end else begin
      inst_sram_data_ok <= r_hs;
      if (r_hs) begin
        inst_sram_rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: a cycle table for the basic and
// backpressure flows, then hand sequences for limit, overlap, write and reset cases.
module tb_inst_axi_rd_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  axi_arid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .INST_ARID(4'h0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .axi_arid(axi_arid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        ar_rdy;
    logic        r_vld;
    logic [31:0] r_dat;
    logic        e_addr_ok;
    logic        e_arvalid;
    logic [31:0] e_araddr;
    logic [2:0]  e_arsize;
    logic        e_data_ok;
    logic [31:0] e_rdata;
    logic [3:0]  e_arid;
    logic        e_rready;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic ar_rdy,
                        input logic r_vld, input logic [31:0] r_dat);
    inst_sram_req  = req;
    inst_sram_wr   = wr;
    inst_sram_addr = addr;
    inst_sram_size = size;
    arready        = ar_rdy;
    rvalid         = r_vld;
    rdata          = r_dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic [1:0] size,
                              input logic ar_rdy, input logic r_vld, input logic [31:0] r_dat,
                              input logic e_aok, input logic e_arv, input logic [31:0] e_ara,
                              input logic [2:0] e_ars, input logic e_dok, input logic [31:0] e_rd,
                              input logic [3:0] e_id, input logic e_rr);
    vec_t v;
    v.req = req;       v.wr = 1'b0;         v.addr = addr;       v.size = size;
    v.ar_rdy = ar_rdy; v.r_vld = r_vld;     v.r_dat = r_dat;
    v.e_addr_ok = e_aok; v.e_arvalid = e_arv; v.e_araddr = e_ara; v.e_arsize = e_ars;
    v.e_data_ok = e_dok; v.e_rdata = e_rd;    v.e_arid = e_id;    v.e_rready = e_rr;
    return v;
  endfunction

  initial begin
    // Single read, then AR backpressure with a second pending request and two R beats.
    vecs[0]  = mk(1, 32'h1c000000, 2'd2, 1, 0, 32'h0,        1, 0, 32'h0,        3'd0, 0, 32'h0,        4'h0, 0);
    vecs[1]  = mk(0, 32'h0,        2'd0, 1, 0, 32'h0,        0, 1, 32'h1c000000, 3'd2, 0, 32'h0,        4'h1, 1);
    vecs[2]  = mk(0, 32'h0,        2'd0, 0, 1, 32'h02800000, 0, 0, 32'h1c000000, 3'd2, 0, 32'h0,        4'h1, 1);
    vecs[3]  = mk(0, 32'h0,        2'd0, 0, 0, 32'h0,        0, 0, 32'h1c000000, 3'd2, 1, 32'h02800000, 4'h0, 0);
    vecs[4]  = mk(0, 32'h0,        2'd0, 0, 0, 32'h0,        0, 0, 32'h1c000000, 3'd2, 0, 32'h02800000, 4'h0, 0);
    vecs[5]  = mk(1, 32'h1c000004, 2'd1, 0, 0, 32'h0,        1, 0, 32'h1c000000, 3'd2, 0, 32'h02800000, 4'h0, 0);
    vecs[6]  = mk(1, 32'h1c000008, 2'd0, 0, 0, 32'h0,        0, 1, 32'h1c000004, 3'd1, 0, 32'h02800000, 4'h1, 1);
    vecs[7]  = mk(1, 32'h1c000008, 2'd0, 0, 0, 32'h0,        0, 1, 32'h1c000004, 3'd1, 0, 32'h02800000, 4'h1, 1);
    vecs[8]  = mk(1, 32'h1c000008, 2'd0, 0, 0, 32'h0,        0, 1, 32'h1c000004, 3'd1, 0, 32'h02800000, 4'h1, 1);
    vecs[9]  = mk(1, 32'h1c000008, 2'd0, 1, 0, 32'h0,        0, 1, 32'h1c000004, 3'd1, 0, 32'h02800000, 4'h1, 1);
    vecs[10] = mk(1, 32'h1c000008, 2'd0, 0, 0, 32'h0,        1, 0, 32'h1c000004, 3'd1, 0, 32'h02800000, 4'h1, 1);
    vecs[11] = mk(0, 32'h0,        2'd0, 1, 0, 32'h0,        0, 1, 32'h1c000008, 3'd0, 0, 32'h02800000, 4'h1, 1);
    vecs[12] = mk(0, 32'h0,        2'd0, 0, 1, 32'haaaa0001, 0, 0, 32'h1c000008, 3'd0, 0, 32'h02800000, 4'h1, 1);
    vecs[13] = mk(0, 32'h0,        2'd0, 0, 1, 32'haaaa0002, 0, 0, 32'h1c000008, 3'd0, 1, 32'haaaa0001, 4'h1, 1);
    vecs[14] = mk(0, 32'h0,        2'd0, 0, 0, 32'h0,        0, 0, 32'h1c000008, 3'd0, 1, 32'haaaa0002, 4'h0, 0);
    vecs[15] = mk(0, 32'h0,        2'd0, 0, 1, 32'hdeadbeef, 0, 0, 32'h1c000008, 3'd0, 0, 32'haaaa0002, 4'h0, 0);
    vecs[16] = mk(0, 32'h0,        2'd0, 0, 0, 32'h0,        0, 0, 32'h1c000008, 3'd0, 0, 32'haaaa0002, 4'h0, 0);

    inst_sram_wstrb = 4'h0;
    inst_sram_wdata = 32'h0;
    rid   = 4'h0;
    rresp = 2'b00;
    rlast = 1'b1;
    set_in(1, 0, 32'h12345678, 2'd2, 1, 1, 32'h11111111);
    resetn = 1'b0;

    // Reset state, with a live request and R beat on the inputs.
    repeat (2) @(negedge clk);
    check("rst addr_ok",  32'(inst_sram_addr_ok), 32'h0);
    check("rst arvalid",  32'(arvalid),           32'h0);
    check("rst araddr",   araddr,                 32'h0);
    check("rst arsize",   32'(arsize),            32'h0);
    check("rst rready",   32'(rready),            32'h0);
    check("rst data_ok",  32'(inst_sram_data_ok), 32'h0);
    check("rst rdata",    inst_sram_rdata,        32'h0);
    check("rst axi_arid", 32'(axi_arid),          32'h0);
    check("const ar", {arid, arlen, 2'b00, arburst, arlock, arcache, 3'b000, arprot, 4'h0},
          {4'h0, 8'h00, 2'b00, 2'b01, 2'b00, 4'h0, 3'b000, 3'b000, 4'h0});
    set_in(0, 0, 32'h0, 2'd0, 0, 0, 32'h0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].size,
             vecs[i].ar_rdy, vecs[i].r_vld, vecs[i].r_dat);
      @(negedge clk);
      check($sformatf("v%0d addr_ok", i),  32'(inst_sram_addr_ok), 32'(vecs[i].e_addr_ok));
      check($sformatf("v%0d arvalid", i),  32'(arvalid),           32'(vecs[i].e_arvalid));
      check($sformatf("v%0d araddr", i),   araddr,                 vecs[i].e_araddr);
      check($sformatf("v%0d arsize", i),   32'(arsize),            32'(vecs[i].e_arsize));
      check($sformatf("v%0d data_ok", i),  32'(inst_sram_data_ok), 32'(vecs[i].e_data_ok));
      check($sformatf("v%0d rdata", i),    inst_sram_rdata,        vecs[i].e_rdata);
      check($sformatf("v%0d axi_arid", i), 32'(axi_arid),          32'(vecs[i].e_arid));
      check($sformatf("v%0d rready", i),   32'(rready),            32'(vecs[i].e_rready));
      tick();
    end

    // Outstanding limit: three requests, R withheld, data order A, B, C.
    set_in(1, 0, 32'h00000100, 2'd2, 1, 0, 32'h0);
    @(negedge clk); check("lim A addr_ok", 32'(inst_sram_addr_ok), 32'h1);
    tick();
    set_in(1, 0, 32'h00000104, 2'd2, 1, 0, 32'h0);
    @(negedge clk); check("lim A araddr", araddr, 32'h00000100);
    check("lim B blocked by arvalid", 32'(inst_sram_addr_ok), 32'h0);
    tick();
    @(negedge clk); check("lim B addr_ok", 32'(inst_sram_addr_ok), 32'h1);
    tick();
    set_in(1, 0, 32'h00000108, 2'd2, 1, 0, 32'h0);
    @(negedge clk); check("lim B araddr", araddr, 32'h00000104);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("lim C held %0d", i), 32'(inst_sram_addr_ok), 32'h0);
      tick();
    end
    set_in(1, 0, 32'h00000108, 2'd2, 1, 1, 32'hda000001);
    @(negedge clk); check("lim C held at R", 32'(inst_sram_addr_ok), 32'h0);
    tick();
    set_in(1, 0, 32'h00000108, 2'd2, 1, 0, 32'h0);
    @(negedge clk);
    check("lim C addr_ok", 32'(inst_sram_addr_ok), 32'h1);
    check("lim A data_ok", 32'(inst_sram_data_ok), 32'h1);
    check("lim A rdata", inst_sram_rdata, 32'hda000001);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 1, 0, 32'h0);
    @(negedge clk); check("lim C araddr", araddr, 32'h00000108);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 0, 1, 32'hdb000002);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 0, 1, 32'hdc000003);
    @(negedge clk);
    check("lim B data_ok", 32'(inst_sram_data_ok), 32'h1);
    check("lim B rdata", inst_sram_rdata, 32'hdb000002);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 0, 0, 32'h0);
    @(negedge clk);
    check("lim C data_ok", 32'(inst_sram_data_ok), 32'h1);
    check("lim C rdata", inst_sram_rdata, 32'hdc000003);
    check("lim drained rready", 32'(rready), 32'h0);
    tick();

    // Accept and R handshake in the same cycle with cnt = 1.
    set_in(1, 0, 32'h00000200, 2'd2, 1, 0, 32'h0);
    @(negedge clk); check("sim D addr_ok", 32'(inst_sram_addr_ok), 32'h1);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 1, 0, 32'h0);
    tick();
    set_in(1, 0, 32'h00000204, 2'd1, 1, 1, 32'hd1d1d1d1);
    @(negedge clk);
    check("sim E addr_ok", 32'(inst_sram_addr_ok), 32'h1);
    check("sim rready", 32'(rready), 32'h1);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 1, 0, 32'h0);
    @(negedge clk);
    check("sim D data_ok", 32'(inst_sram_data_ok), 32'h1);
    check("sim D rdata", inst_sram_rdata, 32'hd1d1d1d1);
    check("sim E arvalid", 32'(arvalid), 32'h1);
    check("sim E araddr", araddr, 32'h00000204);
    check("sim E arsize", 32'(arsize), 32'h1);
    check("sim cnt kept", 32'(rready), 32'h1);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 0, 1, 32'he1e1e1e1);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 0, 0, 32'h0);
    @(negedge clk);
    check("sim E rdata", inst_sram_rdata, 32'he1e1e1e1);
    check("sim cnt zero rready", 32'(rready), 32'h0);
    check("sim idle axi_arid", 32'(axi_arid), 32'h0);
    tick();

    // Write requests are never accepted.
    set_in(1, 1, 32'h00000300, 2'd2, 1, 0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("wr addr_ok %0d", i), 32'(inst_sram_addr_ok), 32'h0);
      check($sformatf("wr arvalid %0d", i), 32'(arvalid), 32'h0);
      tick();
    end

    // Async reset in AR_SEND with cnt = 1, then a stray R beat.
    set_in(1, 0, 32'h00000400, 2'd2, 0, 0, 32'h0);
    tick();
    @(negedge clk); check("rs in send", 32'(arvalid), 32'h1);
    #1 resetn = 1'b0;
    #1;
    check("rs arvalid",  32'(arvalid),           32'h0);
    check("rs araddr",   araddr,                 32'h0);
    check("rs arsize",   32'(arsize),            32'h0);
    check("rs rready",   32'(rready),            32'h0);
    check("rs addr_ok",  32'(inst_sram_addr_ok), 32'h0);
    check("rs rdata",    inst_sram_rdata,        32'h0);
    check("rs axi_arid", 32'(axi_arid),          32'h0);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 0, 1, 32'hbadbad00);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    @(negedge clk); check("stray rready", 32'(rready), 32'h0);
    tick();
    set_in(0, 0, 32'h0, 2'd0, 0, 0, 32'h0);
    @(negedge clk);
    check("stray data_ok", 32'(inst_sram_data_ok), 32'h0);
    check("stray rdata", inst_sram_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
